// File: rtl/xnor_match_pkg.sv
// Shared types and width helper for the bit-serial XNOR match engine.
package xnor_match_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xm_state_t;

    // Ceiling log2, never below 1 so derived vectors keep at least one bit.
    function automatic int clog2w(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/xnor_match_ctrl_xnorgate.sv
// Shared 2-input XNOR cell; c is 1 when the two input bits agree.
module xnorgate (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = ~(a ^ b);

endmodule

// File: rtl/xnor_match_ctrl.sv
// Bit-serial match counter: streams operand bits LSB first through one xnorgate.
// Optional XNOR_MATCH_EARLY_EXIT_EN stops at the first mismatching bit.
module xnor_match_ctrl
    import xnor_match_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = clog2w(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_cnt,
    output logic             equal,
    output logic             busy
);

    localparam int IDX_W = clog2w(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    xm_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             equal_q, equal_d;

    logic bit_a, bit_b, bit_match;
    logic last_bit;

    assign bit_a = a_q[idx_q];
    assign bit_b = b_q[idx_q];

    xnorgate u_xnor (
        .a (bit_a),
        .b (bit_b),
        .c (bit_match)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_cnt_d = res_cnt_q;
        equal_d   = equal_q;
        last_bit  = (idx_q == IDX_LAST);
`ifdef XNOR_MATCH_EARLY_EXIT_EN
        last_bit  = last_bit || !bit_match;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(bit_match);
                // Result is captured separately so it survives the next accept.
                if (last_bit) begin
                    res_cnt_d = cnt_d;
                    equal_d   = (cnt_d == CNT_W'(WIDTH));
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_cnt_q <= '0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_cnt_q <= res_cnt_d;
            equal_q   <= equal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign match_cnt = res_cnt_q;
    assign equal     = equal_q;

endmodule

// File: tb/tb_xnor_match_ctrl.sv
// Directed checks of xnor_match_ctrl at WIDTH=8 and WIDTH=1.
module tb_xnor_match_ctrl;

`ifdef XNOR_MATCH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, equal, busy;
    logic [3:0] match_cnt;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, equal1, busy1;
    logic [0:0] match_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xnor_match_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .match_cnt(match_cnt), .equal(equal), .busy(busy)
    );

    xnor_match_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .match_cnt(match_cnt1), .equal(equal1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lat = rising edges from the accept edge (inclusive) until out_valid is seen
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input int exp_cnt, input bit exp_eq, input int lat);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                in_valid = 1'b0;
                a = ~va; b = va;
                check({tag, "_busy"}, busy, 1);
            end
            if (i == lat - 1) check({tag, "_early_valid"}, out_valid, 0);
            if (i == lat) begin
                check({tag, "_valid"}, out_valid, 1);
                check({tag, "_cnt"}, match_cnt, exp_cnt);
                check({tag, "_eq"}, equal, exp_eq);
            end
        end
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_held_cnt"}, match_cnt, exp_cnt);
    endtask

    task automatic run_op1(input string tag, input logic va, input logic vb,
                           input int exp_cnt, input bit exp_eq);
        @(negedge clk);
        a1 = va; b1 = vb; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check({tag, "_early_valid"}, out_valid1, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid1, 1);
        check({tag, "_cnt"}, match_cnt1, exp_cnt);
        check({tag, "_eq"}, equal1, exp_eq);
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, in_ready1, 1);
    endtask

    initial begin
        int bp_cnt, bp_lat;
        bit saw_valid;

        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_equal", equal, 0);
        check("rst_busy", busy, 0);
        check("rst_w1_ready", in_ready1, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("a5_a5", 8'hA5, 8'hA5, 8, 1'b1, 9);
        run_op("ff_00", 8'hFF, 8'h00, 0, 1'b0, EE ? 2 : 9);
        run_op("f0_f1", 8'hF0, 8'hF1, EE ? 0 : 7, 1'b0, EE ? 2 : 9);
        run_op("0f_8f", 8'h0F, 8'h8F, 7, 1'b0, 9);
        run_op("12_16", 8'h12, 8'h16, EE ? 2 : 7, 1'b0, EE ? 4 : 9);

        // Backpressure in DONE with ignored in_valid pulses.
        bp_cnt = EE ? 0 : 6;
        bp_lat = EE ? 2 : 9;
        @(negedge clk);
        a = 8'h3C; b = 8'h35; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 1; i <= bp_lat; i++) begin
            @(posedge clk); #1;
            if (i == 1) in_valid = 1'b0;
        end
        check("bp_valid", out_valid, 1);
        check("bp_cnt", match_cnt, bp_cnt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_cnt", match_cnt, bp_cnt);
            check("bp_hold_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_exit_valid", out_valid, 0);
        check("bp_exit_ready", in_ready, 1);
        check("bp_exit_busy", busy, 0);
        check("bp_exit_cnt", match_cnt, bp_cnt);

        // Asynchronous reset during RUN discards the partial result.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", match_cnt, 0);
        check("mid_rst_eq", equal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", saw_valid, 0);
        run_op("post_rst", 8'h5A, 8'h5A, 8, 1'b1, 9);

        run_op1("w1_match", 1'b1, 1'b1, 1, 1'b1);
        run_op1("w1_miss", 1'b0, 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
